mem_port_arbiter: RTL and testbench

- Shares the single memory read/write port between two cache clients: client 0 is the instruction cache, client 1 is the data cache.
- Both clients use the same valid/ready request and valid-pulse response protocol as the memory side.
- Only one memory transaction is outstanding at a time.
- Grants alternate round-robin between clients so neither starves.

---
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory read/write port between the
// instruction cache (client 0) and the data cache (client 1).
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int LINE_WIDTH = 128
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    c0_r_req_valid,
  output logic                    c0_r_req_ready,
  input  logic [ADDR_WIDTH-1:0]   c0_r_req_addr,
  input  logic                    c0_w_req_valid,
  output logic                    c0_w_req_ready,
  input  logic [ADDR_WIDTH-1:0]   c0_w_req_addr,
  input  logic [LINE_WIDTH-1:0]   c0_w_req_data,
  input  logic [LINE_WIDTH/8-1:0] c0_w_req_wmask,
  output logic                    c0_r_resp_valid,
  output logic [LINE_WIDTH-1:0]   c0_r_resp_data,
  output logic                    c0_w_resp_valid,

  input  logic                    c1_r_req_valid,
  output logic                    c1_r_req_ready,
  input  logic [ADDR_WIDTH-1:0]   c1_r_req_addr,
  input  logic                    c1_w_req_valid,
  output logic                    c1_w_req_ready,
  input  logic [ADDR_WIDTH-1:0]   c1_w_req_addr,
  input  logic [LINE_WIDTH-1:0]   c1_w_req_data,
  input  logic [LINE_WIDTH/8-1:0] c1_w_req_wmask,
  output logic                    c1_r_resp_valid,
  output logic [LINE_WIDTH-1:0]   c1_r_resp_data,
  output logic                    c1_w_resp_valid,

  output logic                    mem_r_req_valid,
  input  logic                    mem_r_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_r_req_addr,
  input  logic                    mem_r_resp_valid,
  input  logic [LINE_WIDTH-1:0]   mem_r_resp_data,
  output logic                    mem_w_req_valid,
  input  logic                    mem_w_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_w_req_addr,
  output logic [LINE_WIDTH-1:0]   mem_w_req_data,
  output logic [LINE_WIDTH/8-1:0] mem_w_req_wmask,
  input  logic                    mem_w_resp_valid,

  output logic                    busy,
  output logic                    owner,
  output logic                    protocol_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                  state;
  logic                    ptr;
  logic                    op_w;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LINE_WIDTH-1:0]   data_q;
  logic [LINE_WIDTH/8-1:0] mask_q;

  logic                    req0, req1, grant1, sel_w;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [LINE_WIDTH-1:0]   sel_data;
  logic [LINE_WIDTH/8-1:0] sel_mask;
  logic                    r_accept, w_accept, r_done, w_done, done, err_evt;

  // Pointer high favours client 1 when both clients request; write beats read.
  assign req0     = c0_r_req_valid | c0_w_req_valid;
  assign req1     = c1_r_req_valid | c1_w_req_valid;
  assign grant1   = req1 & (~req0 | ptr);
  assign sel_w    = grant1 ? c1_w_req_valid : c0_w_req_valid;
  assign sel_addr = grant1 ? (c1_w_req_valid ? c1_w_req_addr : c1_r_req_addr)
                           : (c0_w_req_valid ? c0_w_req_addr : c0_r_req_addr);
  assign sel_data = grant1 ? c1_w_req_data  : c0_w_req_data;
  assign sel_mask = grant1 ? c1_w_req_wmask : c0_w_req_wmask;

  assign r_accept = mem_r_req_valid & mem_r_req_ready;
  assign w_accept = mem_w_req_valid & mem_w_req_ready;
  assign r_done   = (state == WAIT) & ~op_w & mem_r_resp_valid;
  assign w_done   = (state == WAIT) &  op_w & mem_w_resp_valid;
  assign done     = r_done | w_done;

  // Responses outside WAIT, of the wrong type, or both at once are protocol errors.
  assign err_evt = (mem_r_resp_valid & mem_w_resp_valid)
                 | ((state != WAIT) & (mem_r_resp_valid | mem_w_resp_valid))
                 | ((state == WAIT) & (op_w ? mem_r_resp_valid : mem_w_resp_valid));

  // Handshakes are suppressed during reset so an abandoned transaction never reaches a client.
  assign c0_r_req_ready  = ~rst & r_accept & ~owner;
  assign c0_w_req_ready  = ~rst & w_accept & ~owner;
  assign c1_r_req_ready  = ~rst & r_accept &  owner;
  assign c1_w_req_ready  = ~rst & w_accept &  owner;
  assign c0_r_resp_valid = ~rst & r_done & ~owner;
  assign c0_w_resp_valid = ~rst & w_done & ~owner;
  assign c1_r_resp_valid = ~rst & r_done &  owner;
  assign c1_w_resp_valid = ~rst & w_done &  owner;
  assign c0_r_resp_data  = mem_r_resp_data;
  assign c1_r_resp_data  = mem_r_resp_data;

  assign mem_r_req_addr  = addr_q;
  assign mem_w_req_addr  = addr_q;
  assign mem_w_req_data  = data_q;
  assign mem_w_req_wmask = mask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= 1'b0;
      owner           <= 1'b0;
      busy            <= 1'b0;
      op_w            <= 1'b0;
      addr_q          <= '0;
      data_q          <= '0;
      mask_q          <= '0;
      mem_r_req_valid <= 1'b0;
      mem_w_req_valid <= 1'b0;
      protocol_err    <= 1'b0;
    end else begin
      if (err_evt) protocol_err <= 1'b1;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            state           <= REQ;
            busy            <= 1'b1;
            owner           <= grant1;
            op_w            <= sel_w;
            addr_q          <= sel_addr;
            data_q          <= sel_data;
            mask_q          <= sel_mask;
            mem_r_req_valid <= ~sel_w;
            mem_w_req_valid <= sel_w;
          end
        end
        REQ: begin
          if (r_accept | w_accept) begin
            state           <= WAIT;
            mem_r_req_valid <= 1'b0;
            mem_w_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (done) begin
            state <= IDLE;
            busy  <= 1'b0;
            owner <= 1'b0;
            ptr   <= ~owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner
// sequences, and randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW = 8;
  localparam int LW = 128;
  localparam int MW = LW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          c0_r_req_valid, c0_r_req_ready, c0_w_req_valid, c0_w_req_ready;
  logic [AW-1:0] c0_r_req_addr, c0_w_req_addr;
  logic [LW-1:0] c0_w_req_data, c0_r_resp_data;
  logic [MW-1:0] c0_w_req_wmask;
  logic          c0_r_resp_valid, c0_w_resp_valid;
  logic          c1_r_req_valid, c1_r_req_ready, c1_w_req_valid, c1_w_req_ready;
  logic [AW-1:0] c1_r_req_addr, c1_w_req_addr;
  logic [LW-1:0] c1_w_req_data, c1_r_resp_data;
  logic [MW-1:0] c1_w_req_wmask;
  logic          c1_r_resp_valid, c1_w_resp_valid;
  logic          mem_r_req_valid, mem_r_req_ready, mem_r_resp_valid;
  logic [AW-1:0] mem_r_req_addr, mem_w_req_addr;
  logic [LW-1:0] mem_r_resp_data, mem_w_req_data;
  logic          mem_w_req_valid, mem_w_req_ready, mem_w_resp_valid;
  logic [MW-1:0] mem_w_req_wmask;
  logic          busy, owner, protocol_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .c0_r_req_valid(c0_r_req_valid), .c0_r_req_ready(c0_r_req_ready), .c0_r_req_addr(c0_r_req_addr),
    .c0_w_req_valid(c0_w_req_valid), .c0_w_req_ready(c0_w_req_ready), .c0_w_req_addr(c0_w_req_addr),
    .c0_w_req_data(c0_w_req_data), .c0_w_req_wmask(c0_w_req_wmask),
    .c0_r_resp_valid(c0_r_resp_valid), .c0_r_resp_data(c0_r_resp_data), .c0_w_resp_valid(c0_w_resp_valid),
    .c1_r_req_valid(c1_r_req_valid), .c1_r_req_ready(c1_r_req_ready), .c1_r_req_addr(c1_r_req_addr),
    .c1_w_req_valid(c1_w_req_valid), .c1_w_req_ready(c1_w_req_ready), .c1_w_req_addr(c1_w_req_addr),
    .c1_w_req_data(c1_w_req_data), .c1_w_req_wmask(c1_w_req_wmask),
    .c1_r_resp_valid(c1_r_resp_valid), .c1_r_resp_data(c1_r_resp_data), .c1_w_resp_valid(c1_w_resp_valid),
    .mem_r_req_valid(mem_r_req_valid), .mem_r_req_ready(mem_r_req_ready), .mem_r_req_addr(mem_r_req_addr),
    .mem_r_resp_valid(mem_r_resp_valid), .mem_r_resp_data(mem_r_resp_data),
    .mem_w_req_valid(mem_w_req_valid), .mem_w_req_ready(mem_w_req_ready), .mem_w_req_addr(mem_w_req_addr),
    .mem_w_req_data(mem_w_req_data), .mem_w_req_wmask(mem_w_req_wmask), .mem_w_resp_valid(mem_w_resp_valid),
    .busy(busy), .owner(owner), .protocol_err(protocol_err)
  );

  typedef struct {
    logic       c0r, c0w, c1r, c1w;
    logic [7:0] a0r, a0w, a1r, a1w;
    logic [1:0] exp_v;
    logic [7:0] exp_a;
    logic       exp_own;
  } vec_t;

  vec_t          vecs[7];
  int            checks = 0;
  int            failures = 0;
  int            clients_done;
  logic [LW-1:0] last_rdata;

  task automatic check_output(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ready_vec();
    return {c0_r_req_ready, c0_w_req_ready, c1_r_req_ready, c1_w_req_ready};
  endfunction

  function automatic logic [3:0] resp_vec();
    return {c0_r_resp_valid, c0_w_resp_valid, c1_r_resp_valid, c1_w_resp_valid};
  endfunction

  // Bit order matches ready_vec/resp_vec: {c0 r, c0 w, c1 r, c1 w}.
  function automatic logic [3:0] onehot(input logic own, input logic w);
    return own ? (w ? 4'b0001 : 4'b0010) : (w ? 4'b0100 : 4'b1000);
  endfunction

  task automatic clear_inputs();
    {c0_r_req_valid, c0_w_req_valid, c1_r_req_valid, c1_w_req_valid} = '0;
    {c0_r_req_addr, c0_w_req_addr, c1_r_req_addr, c1_w_req_addr} = '0;
    {c0_w_req_data, c1_w_req_data, c0_w_req_wmask, c1_w_req_wmask} = '0;
    {mem_r_req_ready, mem_w_req_ready, mem_r_resp_valid, mem_w_resp_valid} = '0;
    mem_r_resp_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    c0_r_req_valid = v.c0r; c0_w_req_valid = v.c0w;
    c1_r_req_valid = v.c1r; c1_w_req_valid = v.c1w;
    c0_r_req_addr  = v.a0r; c0_w_req_addr  = v.a0w;
    c1_r_req_addr  = v.a1r; c1_w_req_addr  = v.a1w;
    c0_w_req_data  = {16{8'hC0}}; c1_w_req_data = {16{8'hC1}};
    c0_w_req_wmask = 16'h00FF;    c1_w_req_wmask = 16'hFF00;
  endtask

  // Serves one transaction with a zero-wait memory, starting from an IDLE cycle.
  task automatic run_round(input logic own, input logic w, input logic [7:0] a, input logic [LW-1:0] rd);
    step();
    if (w) mem_w_req_ready = 1'b1; else mem_r_req_ready = 1'b1;
    @(negedge clk);
    check_output("round_owner", owner, own);
    check_output("round_mem_valid", {mem_r_req_valid, mem_w_req_valid}, {~w, w});
    check_output("round_addr", w ? mem_w_req_addr : mem_r_req_addr, a);
    check_output("round_client_ready", ready_vec(), onehot(own, w));
    step();
    if (own) begin
      if (w) c1_w_req_valid = 1'b0; else c1_r_req_valid = 1'b0;
    end else begin
      if (w) c0_w_req_valid = 1'b0; else c0_r_req_valid = 1'b0;
    end
    {mem_r_req_ready, mem_w_req_ready} = '0;
    if (w) mem_w_resp_valid = 1'b1;
    else begin
      mem_r_resp_valid = 1'b1;
      mem_r_resp_data  = rd;
    end
    @(negedge clk);
    check_output("round_resp", resp_vec(), onehot(own, w));
    if (!w) check_output("round_rdata", own ? c1_r_resp_data : c0_r_resp_data, rd);
    step();
    {mem_r_resp_valid, mem_w_resp_valid} = '0;
    @(negedge clk);
    check_output("round_resp_single", resp_vec(), 4'b0000);
    check_output("round_idle_busy", busy, 1'b0);
  endtask

  task automatic drive_client(input int id, input logic r, input logic w, input logic [7:0] ra,
                              input logic [7:0] wa, input logic [LW-1:0] wd, input logic [MW-1:0] wm);
    if (id == 0) begin
      c0_r_req_valid = r; c0_w_req_valid = w; c0_r_req_addr = ra; c0_w_req_addr = wa;
      c0_w_req_data = wd; c0_w_req_wmask = wm;
    end else begin
      c1_r_req_valid = r; c1_w_req_valid = w; c1_r_req_addr = ra; c1_w_req_addr = wa;
      c1_w_req_data = wd; c1_w_req_wmask = wm;
    end
  endtask

  // A cache client: read, write, or writeback+allocate, holding each valid until its ready.
  task automatic client_proc(input int id, input int n);
    logic          need_r, need_w, exp_r, exp_w, got_r, got_w;
    logic [1:0]    rdy, rsp;
    logic [7:0]    ra, wa;
    logic [LW-1:0] wd, rdata;
    logic [MW-1:0] wm;
    int            kind, waitc;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) step();
      kind   = $urandom_range(0, 2);
      need_r = (kind != 1); need_w = (kind != 0);
      exp_r  = need_r;      exp_w  = need_w;
      got_r  = 1'b0;        got_w  = 1'b0;
      ra = 8'($urandom); wa = 8'($urandom); wm = 16'($urandom);
      wd = {$urandom, $urandom, $urandom, $urandom};
      drive_client(id, need_r, need_w, ra, wa, wd, wm);
      waitc = 0;
      while (!(got_r == exp_r && got_w == exp_w) && waitc < 300) begin
        @(negedge clk);
        rdy   = (id == 0) ? {c0_r_req_ready, c0_w_req_ready} : {c1_r_req_ready, c1_w_req_ready};
        rsp   = (id == 0) ? {c0_r_resp_valid, c0_w_resp_valid} : {c1_r_resp_valid, c1_w_resp_valid};
        rdata = (id == 0) ? c0_r_resp_data : c1_r_resp_data;
        if (rdy[1]) begin
          if (exp_w) check_output("rand_write_first", got_w, 1'b1);
          need_r = 1'b0;
        end
        if (rdy[0]) need_w = 1'b0;
        if (rsp[0]) got_w = 1'b1;
        if (rsp[1]) begin
          got_r = 1'b1;
          check_output("rand_rdata", rdata, last_rdata);
        end
        waitc++;
        if (!(got_r == exp_r && got_w == exp_w)) begin
          step();
          drive_client(id, need_r, need_w, ra, wa, wd, wm);
        end
      end
      check_output("rand_client_done", {got_r, got_w}, {exp_r, exp_w});
      step();
    end
    drive_client(id, 1'b0, 1'b0, '0, '0, '0, '0);
    clients_done++;
  endtask

  // Memory with random accept latency and random response delay.
  task automatic mem_proc();
    logic outstanding = 1'b0;
    logic op = 1'b0;
    int   cnt = 0;
    while (clients_done < 2) begin
      step();
      {mem_r_req_ready, mem_w_req_ready, mem_r_resp_valid, mem_w_resp_valid} = '0;
      if (outstanding) begin
        cnt--;
        if (cnt == 0) begin
          outstanding = 1'b0;
          if (op) mem_w_resp_valid = 1'b1;
          else begin
            last_rdata       = {$urandom, $urandom, $urandom, $urandom};
            mem_r_resp_data  = last_rdata;
            mem_r_resp_valid = 1'b1;
          end
        end
      end else if ((mem_r_req_valid || mem_w_req_valid) && $urandom_range(0, 2) != 0) begin
        op = mem_w_req_valid;
        if (op) mem_w_req_ready = 1'b1; else mem_r_req_ready = 1'b1;
        outstanding = 1'b1;
        cnt = $urandom_range(1, 3);
      end
    end
    {mem_r_req_ready, mem_w_req_ready, mem_r_resp_valid, mem_w_resp_valid} = '0;
  endtask

  // Transaction-level reference: idle -> grant -> request -> wait, round-robin pointer.
  task automatic monitor_proc();
    int            phase = 0;
    logic          ptr_m = 1'b0;
    logic          own = 1'b0, opw = 1'b0, r0, r1;
    logic [7:0]    a = '0;
    logic [LW-1:0] d = '0;
    logic [MW-1:0] m = '0;
    while (clients_done < 2) begin
      @(negedge clk);
      if (phase == 0) begin
        check_output("mon_idle_quiet", {mem_r_req_valid, mem_w_req_valid, ready_vec(), resp_vec()}, '0);
        r0 = c0_r_req_valid | c0_w_req_valid;
        r1 = c1_r_req_valid | c1_w_req_valid;
        if (r0 || r1) begin
          own   = (r0 && r1) ? ptr_m : r1;
          opw   = own ? c1_w_req_valid : c0_w_req_valid;
          a     = own ? (opw ? c1_w_req_addr : c1_r_req_addr) : (opw ? c0_w_req_addr : c0_r_req_addr);
          d     = own ? c1_w_req_data : c0_w_req_data;
          m     = own ? c1_w_req_wmask : c0_w_req_wmask;
          phase = 1;
        end
      end else if (phase == 1) begin
        check_output("mon_req_valid", {mem_r_req_valid, mem_w_req_valid}, {~opw, opw});
        check_output("mon_owner", owner, own);
        check_output("mon_addr", opw ? mem_w_req_addr : mem_r_req_addr, a);
        if (opw) check_output("mon_wfields", {mem_w_req_data, mem_w_req_wmask}, {d, m});
        if (opw ? mem_w_req_ready : mem_r_req_ready) begin
          check_output("mon_client_ready", ready_vec(), onehot(own, opw));
          phase = 2;
        end else check_output("mon_no_ready", ready_vec(), 4'b0000);
      end else begin
        if (opw ? mem_w_resp_valid : mem_r_resp_valid) begin
          check_output("mon_client_resp", resp_vec(), onehot(own, opw));
          ptr_m = ~own;
          phase = 0;
        end
      end
    end
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 8'h12, 8'h13, 8'h14, 2'b10, 8'h11, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h21, 8'h22, 8'h23, 8'h24, 2'b10, 8'h23, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h31, 8'h32, 8'h33, 8'h34, 2'b01, 8'h34, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h41, 8'h42, 8'h43, 8'h44, 2'b01, 8'h42, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h51, 8'h52, 8'h53, 8'h54, 2'b10, 8'h51, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h61, 8'h62, 8'h63, 8'h64, 2'b01, 8'h62, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h71, 8'h72, 8'h73, 8'h74, 2'b01, 8'h74, 1'b1};

    // Arbitration and op-select table: one grant straight after reset.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      apply_stimulus(vecs[i]);
      @(negedge clk);
      check_output("vec_idle_no_valid", {mem_r_req_valid, mem_w_req_valid}, 2'b00);
      step();
      @(negedge clk);
      check_output("vec_mem_valid", {mem_r_req_valid, mem_w_req_valid}, vecs[i].exp_v);
      check_output("vec_addr", vecs[i].exp_v[0] ? mem_w_req_addr : mem_r_req_addr, vecs[i].exp_a);
      check_output("vec_owner", {busy, owner}, {1'b1, vecs[i].exp_own});
    end

    // Reset from a loaded REQ state clears every output.
    do_reset();
    @(negedge clk);
    check_output("rst_flags", {busy, owner, protocol_err, mem_r_req_valid, mem_w_req_valid}, '0);
    check_output("rst_fields", {mem_r_req_addr, mem_w_req_addr, mem_w_req_wmask}, '0);
    check_output("rst_wdata", mem_w_req_data, '0);
    check_output("rst_client", {ready_vec(), resp_vec()}, '0);

    // Single read by client 1.
    do_reset();
    c1_r_req_valid = 1'b1; c1_r_req_addr = 8'h2A;
    run_round(1'b1, 1'b0, 8'h2A, 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF);

    // Contention: 0 first, then 1, then 0 again.
    do_reset();
    c0_r_req_valid = 1'b1; c0_r_req_addr = 8'h01;
    c1_r_req_valid = 1'b1; c1_r_req_addr = 8'h02;
    run_round(1'b0, 1'b0, 8'h01, 128'h1111);
    run_round(1'b1, 1'b0, 8'h02, 128'h2222);
    c0_r_req_valid = 1'b1; c0_r_req_addr = 8'h03;
    c1_r_req_valid = 1'b1; c1_r_req_addr = 8'h04;
    run_round(1'b0, 1'b0, 8'h03, 128'h3333);
    run_round(1'b1, 1'b0, 8'h04, 128'h4444);

    // Writeback then allocate from client 1 with a slow memory write port.
    do_reset();
    c1_w_req_valid = 1'b1; c1_w_req_addr = 8'h13; c1_w_req_wmask = '1;
    c1_w_req_data  = 128'hFEED_0000_1234_5678_9ABC_DEF0_CAFE_F00D;
    c1_r_req_valid = 1'b1; c1_r_req_addr = 8'h27;
    step();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_output("wb_hold_valid", {mem_r_req_valid, mem_w_req_valid}, 2'b01);
      check_output("wb_hold_fields", {mem_w_req_addr, mem_w_req_wmask}, {8'h13, 16'hFFFF});
      check_output("wb_hold_data", mem_w_req_data, 128'hFEED_0000_1234_5678_9ABC_DEF0_CAFE_F00D);
      check_output("wb_hold_ready", ready_vec(), 4'b0000);
      step();
    end
    mem_w_req_ready = 1'b1;
    @(negedge clk);
    check_output("wb_accept", ready_vec(), 4'b0001);
    step();
    c1_w_req_valid = 1'b0; mem_w_req_ready = 1'b0; mem_w_resp_valid = 1'b1;
    @(negedge clk);
    check_output("wb_ack", {resp_vec(), mem_r_req_valid}, {4'b0001, 1'b0});
    step();
    mem_w_resp_valid = 1'b0;
    @(negedge clk);
    check_output("wb_ack_once", {resp_vec(), mem_r_req_valid}, '0);
    run_round(1'b1, 1'b0, 8'h27, 128'h2727);

    // Same client asserting read and write: write goes first.
    do_reset();
    c0_r_req_valid = 1'b1; c0_r_req_addr = 8'h50;
    c0_w_req_valid = 1'b1; c0_w_req_addr = 8'h51; c0_w_req_wmask = 16'h0F0F;
    run_round(1'b0, 1'b1, 8'h51, '0);
    run_round(1'b0, 1'b0, 8'h50, 128'h5050);

    // Wrong-type response while waiting on a read.
    do_reset();
    c0_r_req_valid = 1'b1; c0_r_req_addr = 8'h60;
    step();
    mem_r_req_ready = 1'b1;
    step();
    c0_r_req_valid = 1'b0; mem_r_req_ready = 1'b0; mem_w_resp_valid = 1'b1;
    @(negedge clk);
    check_output("perr_no_resp", resp_vec(), 4'b0000);
    step();
    mem_w_resp_valid = 1'b0;
    @(negedge clk);
    check_output("perr_set_wait", {protocol_err, busy}, 2'b11);
    step();
    step();
    @(negedge clk);
    check_output("perr_hold_wait", {protocol_err, busy}, 2'b11);
    step();
    mem_r_resp_valid = 1'b1; mem_r_resp_data = 128'h6060;
    @(negedge clk);
    check_output("perr_read_done", resp_vec(), 4'b1000);
    step();
    mem_r_resp_valid = 1'b0;
    @(negedge clk);
    check_output("perr_sticky", {protocol_err, busy}, 2'b10);

    // Reset while waiting, then a stray response.
    do_reset();
    c1_r_req_valid = 1'b1; c1_r_req_addr = 8'h70;
    step();
    mem_r_req_ready = 1'b1;
    step();
    c1_r_req_valid = 1'b0; mem_r_req_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_output("midrst_no_resp", resp_vec(), 4'b0000);
    step();
    rst = 1'b0;
    @(negedge clk);
    check_output("midrst_idle", {busy, owner, protocol_err, mem_r_req_valid, mem_w_req_valid, resp_vec()}, '0);
    step();
    mem_r_resp_valid = 1'b1;
    @(negedge clk);
    check_output("midrst_stray_blocked", resp_vec(), 4'b0000);
    step();
    mem_r_resp_valid = 1'b0;
    @(negedge clk);
    check_output("midrst_stray_err", protocol_err, 1'b1);

    // Randomized two-client traffic.
    do_reset();
    clients_done = 0;
    last_rdata = '0;
    fork
      client_proc(0, 25);
      client_proc(1, 25);
      mem_proc();
      monitor_proc();
    join
    @(negedge clk);
    check_output("rand_no_perr", protocol_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
